tlb_search_arb: RTL and testbench
=================================

# tlb_search_arb

Shares the single combinational TLB search port among three requesters: instruction-side MMU, data-side MMU and the CP0 TLBP sequencer. It grants at most one lookup per cycle, drives the TLB search inputs, and registers the search result into a shared response bus with a per-requester valid strobe. It also blocks lookups around TLB writes, and kills in-flight instruction and data responses on a pipeline flush. The block sits between the two MMU front-ends and the TLB array.

## Interface
Parameters:
- TLBNUM, 16, TLB entry count; the index width is $clog2(TLBNUM).
- STARVE_MAX, 4, consecutive denied cycles after which the instruction requester overrides the data requester.
- WR_STALL, 2, number of cycles with no grants after a TLB write strobe.

Ports:
- clk  in  1  clock; everything samples on the rising edge.
- resetn  in  1  synchronous active-low reset.
- i_req / d_req / p_req  in  1  lookup requests: instruction, data, TLBP.
- i_vpn / d_vpn / p_vpn  in  19  VPN2 for each request.
- i_odd / d_odd  in  1  odd-page select; the TLBP search drives s_odd=0.
- i_gnt / d_gnt / p_gnt  out  1  grant, combinational and one-hot.
- asid  in  8  EntryHi ASID; shared by all lookups.
- flush  in  1  pipeline flush (exception or eret).
- tlb_we  in  1  TLBWI/TLBWR write strobe.
- s_vpn  out  19, s_odd  out  1, s_asid  out  8  TLB search inputs.
- s_found  in  1, s_index  in  $clog2(TLBNUM), s_pfn  in  20, s_c  in  3, s_d  in  1, s_v  in  1  TLB search result.
- rsp_found, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v  out  (same widths as s_*)  registered response bus.
- i_rsp_valid / d_rsp_valid / p_rsp_valid  out  1  one-cycle response strobes.

## Operation
- The FSM has two states:
  - RUN: grants allowed.
  - WBLK: no grants; a down-counter is loaded with WR_STALL.
- Transitions:
  - RUN→WBLK when tlb_we=1.
  - WBLK→RUN when the counter reaches 1 and tlb_we=0.
  - tlb_we=1 while in WBLK reloads the counter.
- Grant rules:
  - No grant in a cycle with tlb_we=1, in WBLK, or with resetn=0.
  - flush=1 suppresses i_gnt and d_gnt in that cycle; p_gnt is unaffected.
  - Normal priority: p > d > i.
  - Starvation override: when i_wait == STARVE_MAX, priority is p > i > d.
- i_wait counter:
  - Increments when i_req=1 and i_gnt=0, saturating at STARVE_MAX.
  - Clears on i_gnt or when i_req=0.
- The s_* outputs carry the granted requester's vpn/odd plus asid.
- With no grant, s_* carry the i-side fields; this keeps the search path stable.
- Requesters must hold their req and fields stable until granted.
- The grant drives no other side effects.

## Timing
- Latency: a grant in cycle N produces the registered rsp_* and the matching *_rsp_valid in cycle N+1, for exactly one cycle.
- rsp_* hold their last value between responses.
- flush in cycle N+1 clears the pending i_rsp_valid/d_rsp_valid of that cycle, so it is 0.
- A pending p_rsp_valid is never cleared.
- Reset values:
  - All gnt and *_rsp_valid are 0.
  - All rsp_* are 0.
  - State is RUN; i_wait and the WBLK counter are 0.
- Reset mid-lookup drops the response: no *_rsp_valid the cycle after resetn returns high.
- Simultaneous tlb_we and p_req: no grant; the TLBP is granted after the WBLK period.
- Simultaneous flush and tlb_we: both rules apply, so there is no grant.

## Structure
- Shared package gemini_mmu_pkg:
  - Requester-id constants (REQ_I=0, REQ_D=1, REQ_P=2).
  - VPN2_W=19, PFN_W=20, ASID_W=8.
- Sub-module tlb_arb_prio: a combinational 3-way fixed-priority selector with a starvation swap input. It outputs a one-hot grant vector.
- Top level: FSM, i_wait counter, response register and the flush mask.

## Test plan
- Single request: i_req=1, i_vpn=19'h00400, TLB hit pfn=20'h1F000 with v=1. Expect i_gnt in cycle N, then i_rsp_valid with rsp_pfn=20'h1F000, rsp_found=1 in N+1.
- Contention: i_req=d_req=p_req=1 held. Expect p_gnt, then d_gnt each cycle. After STARVE_MAX=4 denied cycles, i_gnt in the next cycle, then i_wait returns to 0.
- Write block: tlb_we pulse at cycle N with d_req held. Expect no grant in cycles N..N+2, then d_gnt in N+3. A second tlb_we at N+1 extends the block to N+3, with the grant in N+4.
- Flush: d granted at N, flush=1 at N+1. Expect d_rsp_valid=0 at N+1. The same test with p granted expects p_rsp_valid=1.
- Reset: resetn=0 during a granted cycle. Expect all outputs 0, state RUN and no response strobe; normal grants resume the cycle after resetn=1.
- Miss: TLB miss (s_found=0) on a TLBP. Expect p_rsp_valid=1 with rsp_found=0 and the ASID presented on s_asid.

Source files
------------

// File: rtl/gemini_mmu_pkg.sv
// Shared MMU definitions: requester ids, field widths and arbiter state encoding.
package gemini_mmu_pkg;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;
  localparam int REQ_P = 2;
  localparam int NREQ  = 3;

  localparam int VPN2_W = 19;
  localparam int PFN_W  = 20;
  localparam int ASID_W = 8;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WBLK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/tlb_search_arb_if.sv
// Requester, TLB search and response bundle around the TLB search arbiter.
interface tlb_search_arb_if
  import gemini_mmu_pkg::*;
#(
  parameter int TLBNUM = 16
);
  localparam int IDX_W = $clog2(TLBNUM);

  logic              i_req, d_req, p_req;
  logic [VPN2_W-1:0] i_vpn, d_vpn, p_vpn;
  logic              i_odd, d_odd;
  logic              i_gnt, d_gnt, p_gnt;
  logic [ASID_W-1:0] asid;
  logic              flush;
  logic              tlb_we;

  logic [VPN2_W-1:0] s_vpn;
  logic              s_odd;
  logic [ASID_W-1:0] s_asid;
  logic              s_found;
  logic [IDX_W-1:0]  s_index;
  logic [PFN_W-1:0]  s_pfn;
  logic [2:0]        s_c;
  logic              s_d, s_v;

  logic              rsp_found;
  logic [IDX_W-1:0]  rsp_index;
  logic [PFN_W-1:0]  rsp_pfn;
  logic [2:0]        rsp_c;
  logic              rsp_d, rsp_v;
  logic              i_rsp_valid, d_rsp_valid, p_rsp_valid;

  modport master (
    output i_req, d_req, p_req, i_vpn, d_vpn, p_vpn, i_odd, d_odd,
           asid, flush, tlb_we, s_found, s_index, s_pfn, s_c, s_d, s_v,
    input  i_gnt, d_gnt, p_gnt, s_vpn, s_odd, s_asid,
           rsp_found, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v,
           i_rsp_valid, d_rsp_valid, p_rsp_valid
  );

  modport slave (
    input  i_req, d_req, p_req, i_vpn, d_vpn, p_vpn, i_odd, d_odd,
           asid, flush, tlb_we, s_found, s_index, s_pfn, s_c, s_d, s_v,
    output i_gnt, d_gnt, p_gnt, s_vpn, s_odd, s_asid,
           rsp_found, rsp_index, rsp_pfn, rsp_c, rsp_d, rsp_v,
           i_rsp_valid, d_rsp_valid, p_rsp_valid
  );

endinterface

// File: rtl/tlb_arb_prio.sv
// Three-way fixed-priority selector (p > d > i); the swap input promotes i above d.
module tlb_arb_prio
  import gemini_mmu_pkg::*;
(
  input  logic [NREQ-1:0] i_reqs,
  input  logic            i_swap,
  output logic [NREQ-1:0] o_gnts
);

  always_comb begin
    o_gnts = '0;
    if (i_reqs[REQ_P]) begin
      o_gnts[REQ_P] = 1'b1;
    end else if (i_swap && i_reqs[REQ_I]) begin
      o_gnts[REQ_I] = 1'b1;
    end else if (i_reqs[REQ_D]) begin
      o_gnts[REQ_D] = 1'b1;
    end else if (i_reqs[REQ_I]) begin
      o_gnts[REQ_I] = 1'b1;
    end
  end

endmodule

// File: rtl/tlb_search_arb.sv
// Shares the TLB search port among I-MMU, D-MMU and TLBP, registering one response per grant.
module tlb_search_arb
  import gemini_mmu_pkg::*;
#(
  parameter int TLBNUM     = 16,
  parameter int STARVE_MAX = 4,
  parameter int WR_STALL   = 2
) (
  input logic             clk,
  input logic             resetn,
  tlb_search_arb_if.slave bus
);

  localparam int IDX_W  = $clog2(TLBNUM);
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  localparam int CNT_W  = $clog2(WR_STALL + 1);

  arb_state_e        r_state, w_stateNxt;
  logic [CNT_W-1:0]  r_cnt, w_cntNxt;
  logic [WAIT_W-1:0] r_iWait;
  logic [NREQ-1:0]   w_req, w_gnt, r_rspVld;
  logic              w_allow, w_swap;

  logic              r_rspFound, r_rspD, r_rspV;
  logic [IDX_W-1:0]  r_rspIndex;
  logic [PFN_W-1:0]  r_rspPfn;
  logic [2:0]        r_rspC;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNxt;
      r_cnt   <= w_cntNxt;
    end
  end

  // A write strobe seen while already blocked restarts the stall window.
  always_comb begin
    w_stateNxt = r_state;
    w_cntNxt   = r_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.tlb_we) begin
          w_stateNxt = ST_WBLK;
          w_cntNxt   = CNT_W'(WR_STALL);
        end
      end
      ST_WBLK: begin
        if (bus.tlb_we) begin
          w_cntNxt = CNT_W'(WR_STALL);
        end else if (r_cnt == CNT_W'(1)) begin
          w_stateNxt = ST_RUN;
          w_cntNxt   = '0;
        end else begin
          w_cntNxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_stateNxt = ST_RUN;
        w_cntNxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_allow      = resetn && (r_state == ST_RUN) && !bus.tlb_we;
    w_swap       = (r_iWait == WAIT_W'(STARVE_MAX));
    w_req        = '0;
    w_req[REQ_P] = w_allow & bus.p_req;
    w_req[REQ_D] = w_allow & ~bus.flush & bus.d_req;
    w_req[REQ_I] = w_allow & ~bus.flush & bus.i_req;
  end

  tlb_arb_prio u_prio (
    .i_reqs (w_req),
    .i_swap (w_swap),
    .o_gnts (w_gnt)
  );

  // With no grant the i-side fields stay on the search port.
  always_comb begin
    bus.s_vpn  = bus.i_vpn;
    bus.s_odd  = bus.i_odd;
    bus.s_asid = bus.asid;
    if (w_gnt[REQ_P]) begin
      bus.s_vpn = bus.p_vpn;
      bus.s_odd = 1'b0;
    end else if (w_gnt[REQ_D]) begin
      bus.s_vpn = bus.d_vpn;
      bus.s_odd = bus.d_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_iWait <= '0;
    end else if (bus.i_req && !w_gnt[REQ_I]) begin
      if (r_iWait != WAIT_W'(STARVE_MAX)) r_iWait <= r_iWait + WAIT_W'(1);
    end else begin
      r_iWait <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rspVld   <= '0;
      r_rspFound <= 1'b0;
      r_rspIndex <= '0;
      r_rspPfn   <= '0;
      r_rspC     <= '0;
      r_rspD     <= 1'b0;
      r_rspV     <= 1'b0;
    end else begin
      r_rspVld <= w_gnt;
      if (|w_gnt) begin
        r_rspFound <= bus.s_found;
        r_rspIndex <= bus.s_index;
        r_rspPfn   <= bus.s_pfn;
        r_rspC     <= bus.s_c;
        r_rspD     <= bus.s_d;
        r_rspV     <= bus.s_v;
      end
    end
  end

  assign bus.i_gnt       = w_gnt[REQ_I];
  assign bus.d_gnt       = w_gnt[REQ_D];
  assign bus.p_gnt       = w_gnt[REQ_P];
  assign bus.rsp_found   = r_rspFound;
  assign bus.rsp_index   = r_rspIndex;
  assign bus.rsp_pfn     = r_rspPfn;
  assign bus.rsp_c       = r_rspC;
  assign bus.rsp_d       = r_rspD;
  assign bus.rsp_v       = r_rspV;
  assign bus.i_rsp_valid = r_rspVld[REQ_I] & ~bus.flush;
  assign bus.d_rsp_valid = r_rspVld[REQ_D] & ~bus.flush;
  assign bus.p_rsp_valid = r_rspVld[REQ_P];

endmodule

// File: tb/tb_tlb_search_arb.sv
// Self-checking bench for tlb_search_arb: vector table, directed sequences and random traffic vs a model.
module tb_tlb_search_arb;
  import gemini_mmu_pkg::*;

  localparam int TLBNUM     = 16;
  localparam int STARVE_MAX = 4;
  localparam int WR_STALL   = 2;

  typedef struct {
    logic       rstn, ir, dr, pr, fl, we;
    logic [2:0] expGnt;
    logic [2:0] expVld;
  } vec_t;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tlb_search_arb_if #(.TLBNUM(TLBNUM)) bus ();

  tlb_search_arb #(
    .TLBNUM     (TLBNUM),
    .STARVE_MAX (STARVE_MAX),
    .WR_STALL   (WR_STALL)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic        tRstn, tIr, tDr, tPr, tFl, tWe, tIo, tDo;
  logic [18:0] tIv, tDv, tPv;
  logic [7:0]  tAsid;
  logic        tFound, tD, tV;
  logic [3:0]  tIndex;
  logic [19:0] tPfn;
  logic [2:0]  tC;

  int nChecks = 0;
  int nFails  = 0;

  // Model: remaining blocked cycles, i-side wait count, pending responder, held response.
  int          mBlk, mWait, mPend;
  logic [29:0] mRsp;

  vec_t vecs[28];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic randomTlb();
    tFound = 1'($urandom);
    tIndex = 4'($urandom);
    tPfn   = 20'($urandom);
    tC     = 3'($urandom);
    tD     = 1'($urandom);
    tV     = 1'($urandom);
  endtask

  task automatic randomFields();
    tIv   = 19'($urandom);
    tDv   = 19'($urandom);
    tPv   = 19'($urandom);
    tIo   = 1'($urandom);
    tDo   = 1'($urandom);
    tAsid = 8'($urandom);
  endtask

  task automatic applyStimulus();
    int          win;
    logic [2:0]  eGnt, eVld;
    logic [18:0] eVpn;
    logic        eOdd;
    @(negedge clk);
    resetn      = tRstn;
    bus.i_req   = tIr;  bus.d_req = tDr;  bus.p_req = tPr;
    bus.i_vpn   = tIv;  bus.d_vpn = tDv;  bus.p_vpn = tPv;
    bus.i_odd   = tIo;  bus.d_odd = tDo;
    bus.asid    = tAsid;
    bus.flush   = tFl;
    bus.tlb_we  = tWe;
    bus.s_found = tFound; bus.s_index = tIndex; bus.s_pfn = tPfn;
    bus.s_c     = tC;     bus.s_d     = tD;     bus.s_v   = tV;
    #1;
    win = -1;
    if (tRstn && mBlk == 0 && !tWe) begin
      if (tPr) win = REQ_P;
      else if (!tFl) begin
        if (mWait == STARVE_MAX && tIr) win = REQ_I;
        else if (tDr) win = REQ_D;
        else if (tIr) win = REQ_I;
      end
    end
    eGnt = '0;
    if (win >= 0) eGnt[win] = 1'b1;
    eVld = '0;
    if (mPend == REQ_P) eVld[REQ_P] = 1'b1;
    else if (mPend >= 0 && !tFl) eVld[mPend] = 1'b1;
    eVpn = (win == REQ_P) ? tPv : (win == REQ_D) ? tDv : tIv;
    eOdd = (win == REQ_P) ? 1'b0 : (win == REQ_D) ? tDo : tIo;
    checkOutput("grant", 64'({bus.p_gnt, bus.d_gnt, bus.i_gnt}), 64'(eGnt));
    checkOutput("rsp_valid", 64'({bus.p_rsp_valid, bus.d_rsp_valid, bus.i_rsp_valid}), 64'(eVld));
    checkOutput("search_bus", 64'({bus.s_vpn, bus.s_odd, bus.s_asid}), 64'({eVpn, eOdd, tAsid}));
    checkOutput("rsp_bus", 64'({bus.rsp_found, bus.rsp_index, bus.rsp_pfn, bus.rsp_c, bus.rsp_d, bus.rsp_v}),
                64'(mRsp));
    if (!tRstn) begin
      mBlk = 0; mWait = 0; mPend = -1; mRsp = '0;
    end else begin
      if (tWe) mBlk = WR_STALL;
      else if (mBlk > 0) mBlk--;
      if (tIr && win != REQ_I) mWait = (mWait < STARVE_MAX) ? mWait + 1 : STARVE_MAX;
      else mWait = 0;
      mPend = win;
      if (win >= 0) mRsp = {tFound, tIndex, tPfn, tC, tD, tV};
    end
  endtask

  initial begin
    // Columns: rstn ir dr pr fl we | grant {p,d,i} | rsp_valid {p,d,i}
    vecs[0]  = '{1,1,1,1,0,0, 3'b100, 3'b000};
    vecs[1]  = '{1,1,1,0,0,0, 3'b010, 3'b100};
    vecs[2]  = '{1,1,1,0,0,0, 3'b010, 3'b010};
    vecs[3]  = '{1,1,1,0,0,0, 3'b010, 3'b010};
    vecs[4]  = '{1,1,1,0,0,0, 3'b001, 3'b010};
    vecs[5]  = '{1,1,1,0,0,0, 3'b010, 3'b001};
    vecs[6]  = '{1,0,1,0,0,1, 3'b000, 3'b010};
    vecs[7]  = '{1,0,1,0,0,0, 3'b000, 3'b000};
    vecs[8]  = '{1,0,1,0,0,0, 3'b000, 3'b000};
    vecs[9]  = '{1,0,1,0,0,0, 3'b010, 3'b000};
    vecs[10] = '{1,0,1,0,0,1, 3'b000, 3'b010};
    vecs[11] = '{1,0,1,0,0,1, 3'b000, 3'b000};
    vecs[12] = '{1,0,1,0,0,0, 3'b000, 3'b000};
    vecs[13] = '{1,0,1,0,0,0, 3'b000, 3'b000};
    vecs[14] = '{1,0,1,0,0,0, 3'b010, 3'b000};
    vecs[15] = '{1,0,0,0,1,0, 3'b000, 3'b000};
    vecs[16] = '{1,0,0,1,0,0, 3'b100, 3'b000};
    vecs[17] = '{1,0,0,0,1,0, 3'b000, 3'b100};
    vecs[18] = '{1,0,1,1,1,0, 3'b100, 3'b000};
    vecs[19] = '{1,0,1,0,0,0, 3'b010, 3'b100};
    vecs[20] = '{1,0,0,1,1,1, 3'b000, 3'b000};
    vecs[21] = '{1,0,0,1,0,0, 3'b000, 3'b000};
    vecs[22] = '{1,0,0,1,0,0, 3'b000, 3'b000};
    vecs[23] = '{1,0,0,1,0,0, 3'b100, 3'b000};
    vecs[24] = '{1,0,0,0,0,0, 3'b000, 3'b100};
    vecs[25] = '{0,0,1,0,0,0, 3'b000, 3'b000};
    vecs[26] = '{1,0,1,0,0,0, 3'b010, 3'b000};
    vecs[27] = '{1,0,0,0,0,0, 3'b000, 3'b010};

    tRstn = 1'b0; tIr = 1'b1; tDr = 1'b1; tPr = 1'b1; tFl = 1'b0; tWe = 1'b0;
    randomFields();
    randomTlb();
    resetn = 1'b0;
    bus.i_req = 1'b0; bus.d_req = 1'b0; bus.p_req = 1'b0;
    bus.flush = 1'b0; bus.tlb_we = 1'b0;
    repeat (2) @(posedge clk);
    mBlk = 0; mWait = 0; mPend = -1; mRsp = '0;

    $display("[TB] reset phase");
    repeat (2) begin
      applyStimulus();
      checkOutput("reset grants", 64'({bus.p_gnt, bus.d_gnt, bus.i_gnt}), 64'h0);
      checkOutput("reset rsp_pfn", 64'(bus.rsp_pfn), 64'h0);
    end

    $display("[TB] vector table");
    for (int k = 0; k < 28; k++) begin
      tRstn = vecs[k].rstn; tIr = vecs[k].ir; tDr = vecs[k].dr;
      tPr   = vecs[k].pr;   tFl = vecs[k].fl; tWe = vecs[k].we;
      randomFields();
      randomTlb();
      applyStimulus();
      checkOutput($sformatf("vec%0d grant", k), 64'({bus.p_gnt, bus.d_gnt, bus.i_gnt}), 64'(vecs[k].expGnt));
      checkOutput($sformatf("vec%0d rsp_valid", k),
                  64'({bus.p_rsp_valid, bus.d_rsp_valid, bus.i_rsp_valid}), 64'(vecs[k].expVld));
    end

    $display("[TB] single i-side hit");
    tRstn = 1; tIr = 1; tDr = 0; tPr = 0; tFl = 0; tWe = 0;
    tIv = 19'h00400; tIo = 1'b0;
    tFound = 1; tIndex = 4'h3; tPfn = 20'h1F000; tC = 3'd3; tD = 1; tV = 1;
    applyStimulus();
    checkOutput("single i_gnt", 64'(bus.i_gnt), 64'h1);
    checkOutput("single s_vpn", 64'(bus.s_vpn), 64'h00400);
    tIr = 0;
    randomTlb();
    applyStimulus();
    checkOutput("single i_rsp_valid", 64'(bus.i_rsp_valid), 64'h1);
    checkOutput("single rsp_pfn", 64'(bus.rsp_pfn), 64'h1F000);
    checkOutput("single rsp_found", 64'(bus.rsp_found), 64'h1);
    applyStimulus();
    checkOutput("single strobe drop", 64'(bus.i_rsp_valid), 64'h0);
    checkOutput("single rsp hold", 64'(bus.rsp_pfn), 64'h1F000);

    $display("[TB] TLBP miss");
    tPr = 1; tPv = 19'h7ABCD; tIo = 1'b1; tAsid = 8'h5A; tFound = 0;
    applyStimulus();
    checkOutput("miss p_gnt", 64'(bus.p_gnt), 64'h1);
    checkOutput("miss s_asid", 64'(bus.s_asid), 64'h5A);
    checkOutput("miss s_odd", 64'(bus.s_odd), 64'h0);
    tPr = 0;
    randomTlb();
    applyStimulus();
    checkOutput("miss p_rsp_valid", 64'(bus.p_rsp_valid), 64'h1);
    checkOutput("miss rsp_found", 64'(bus.rsp_found), 64'h0);

    $display("[TB] random traffic");
    for (int n = 0; n < 500; n++) begin
      tRstn = ($urandom % 32) != 0;
      tIr   = 1'($urandom);
      tDr   = 1'($urandom);
      tPr   = ($urandom % 3) == 0;
      tFl   = ($urandom % 8) == 0;
      tWe   = ($urandom % 10) == 0;
      randomFields();
      randomTlb();
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
